clk_mon_pulse_gen: RTL
======================

// Module: clk_mon_pulse_gen
// PURPOSE
//  Programmable pulse-burst transmitter for the housekeeping clock-monitor pins.
//  Firmware selects a monitor pin, a half-period and an edge count, then starts a burst.
//  Block emits exactly COUNT rising edges on the selected pin; the other pin stays low.
//  Sits in the sysctrl region as a Wishbone slave; outputs route to mprj_io[14] (core) / [15] (user).
// PARAMETERS
//  DIV_W    16  width of DIV register (half-period minus 1, in wb_clk_i cycles)
//  CNT_W    16  width of COUNT register (rising edges per burst)
// PORTS
//  wb_clk_i    in   1   sole clock
//  wb_rst_i    in   1   reset, synchronous, active-high
//  wb_cyc_i    in   1   bus cycle
//  wb_stb_i    in   1   strobe
//  wb_we_i     in   1   write enable
//  wb_sel_i    in   4   byte lanes; a byte is written only when its lane is set
//  wb_adr_i    in   2   word address (byte addr [3:2])
//  wb_dat_i    in   32  write data
//  wb_dat_o    out  32  read data, valid with ack
//  wb_ack_o    out  1   single-cycle ack
//  mon_core_o  out  1   core-clock monitor pin (mprj_io[14])
//  mon_user_o  out  1   user-clock monitor pin (mprj_io[15])
//  irq_o       out  1   level; high while STATUS.done=1
// BEHAVIOUR
//  Reset (synchronous, active-high): all registers 0, state IDLE, all outputs 0.
//  Bus: ack asserted the cycle after cyc&stb; deasserted next cycle; one access per ack.
//   Register effects land on the ack cycle. Unmapped bits read 0.
//  Map: 0 CTRL [0]start(W, self-clear) [1]sel 0=core 1=user [2]abort(W, self-clear)
//       1 DIV[DIV_W-1:0]  2 COUNT[CNT_W-1:0]
//       3 STATUS [0]busy(RO) [1]done(W1C) [2]aborted(W1C) [31:16]edges sent(RO)
//  FSM IDLE -> LOW -> HIGH -> LOW ... -> IDLE. Half-period counter reloads DIV at every phase entry.
//   Phase lasts DIV+1 cycles; output period = 2*(DIV+1).
//   start in IDLE, COUNT!=0: clear done/aborted/edges, latch sel/DIV/COUNT, enter LOW.
//   LOW expiry: enter HIGH, pin=1, edges+1.
//   HIGH expiry: if edges==COUNT then IDLE with done=1, else LOW.
//   First rising edge DIV+1 cycles after the start ack cycle. Pin idles low and ends low.
//  Boundaries
//   - DIV=0: 1-cycle phases.
//   - CTRL.sel/DIV/COUNT writes while busy: ignored; ack still returned.
//   - start while busy: ignored.
//   - abort: IDLE next cycle, pin low, aborted=1, done unchanged. start+abort in one write: abort wins.
//   - W1C of done on the same cycle the FSM sets done: set wins.
//   - wb_rst_i mid-burst: pin low on the following cycle; burst lost.
// CONFIGURATION
//  CLK_MON_FREE_RUN_EN defined: start with COUNT=0 runs continuously until abort.
//   edges counter wraps at 2^16.
//  Undefined: start with COUNT=0 emits no edges and sets done=1 on the ack cycle.
// STRUCTURE
//  clk_mon_pkg: register word offsets, CTRL/STATUS bit positions, FSM state enum.
//  Sub-module clk_mon_regs: Wishbone decode, ack, register/W1C storage.
//  Top: FSM, half-period counter, edge counter, pin mux.
// TESTING
//  1 sel=1, DIV=3, COUNT=11, start -> 11 rising edges on mon_user_o, 0 on mon_core_o.
//    period 8 cycles; done=1, irq_o=1.
//  2 sel=0, DIV=0, COUNT=11 -> 11 edges on mon_core_o, 0 on mon_user_o; first edge 1 cycle after ack.
//  3 COUNT=5, busy; write DIV=9 and start again -> burst unchanged (5 edges, DIV 3 timing).
//    Then W1C done -> irq_o=0.
//  4 COUNT=100, abort after 4 edges -> pin low next cycle, STATUS busy=0 aborted=1 done=0 edges=4.
//  5 COUNT=0, start -> no edges, done=1 (macro off);
//    macro on -> continuous toggling until abort.
//  6 wb_rst_i pulsed mid-burst -> pins 0, all registers 0, no further edges.

Source files
------------

// File: rtl/clk_mon_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : clk_mon_pkg                                                      |
// | Purpose  : Shared definitions for the clock-monitor pulse-burst block:      |
// |            register word offsets, CTRL/STATUS bit positions, FSM states     |
// |            and a byte-lane merge helper.                                    |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
package clk_mon_pkg;

  // Register word offsets (byte address [3:2])
  localparam logic [1:0] C_ADR_CTRL   = 2'd0;
  localparam logic [1:0] C_ADR_DIV    = 2'd1;
  localparam logic [1:0] C_ADR_COUNT  = 2'd2;
  localparam logic [1:0] C_ADR_STATUS = 2'd3;

  // CTRL bit positions
  localparam int C_CTRL_START = 0;
  localparam int C_CTRL_SEL   = 1;
  localparam int C_CTRL_ABORT = 2;

  // STATUS bit positions
  localparam int C_STAT_BUSY      = 0;
  localparam int C_STAT_DONE      = 1;
  localparam int C_STAT_ABORTED   = 2;
  localparam int C_STAT_EDGES_LSB = 16;

  // Width of the edges-sent counter (wraps at 2^16)
  localparam int C_EDGE_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_e;

  // Merge a bus write into an existing 32-bit word, honouring byte lanes.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  lanes);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = lanes[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_mon_regs.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : clk_mon_regs                                                     |
// | Purpose  : Wishbone slave front end: decode, single-cycle ack, CTRL.sel/DIV/ |
// |            COUNT storage and the done/aborted W1C flags.                    |
// | Ports    : wb_*        Wishbone slave (clock, sync active-high reset)       |
// |            busy_i      burst in progress; freezes sel/DIV/COUNT             |
// |            done_set_i / aborted_set_i / start_clr_i  flag controls from FSM |
// |            edges_i     edges-sent count for STATUS[31:16]                   |
// |            start_req_o / abort_req_o  CTRL command pulses (access cycle)    |
// |            sel_next_o  sel value after this cycle's write                   |
// |            div_o / count_o / done_o / aborted_o  register contents          |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module clk_mon_regs
  import clk_mon_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int CNT_W = 16
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [3:0]          wb_sel_i,
  input  logic [1:0]          wb_adr_i,
  input  logic [31:0]         wb_dat_i,
  output logic [31:0]         wb_dat_o,
  output logic                wb_ack_o,
  input  logic                busy_i,
  input  logic                done_set_i,
  input  logic                aborted_set_i,
  input  logic                start_clr_i,
  input  logic [C_EDGE_W-1:0] edges_i,
  output logic                start_req_o,
  output logic                abort_req_o,
  output logic                sel_next_o,
  output logic [DIV_W-1:0]    div_o,
  output logic [CNT_W-1:0]    count_o,
  output logic                done_o,
  output logic                aborted_o
);

  logic             ack_q;
  logic [31:0]      dat_q;
  logic             sel_q, sel_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;

  logic             w_access;
  logic             w_wr;
  logic             w_ctrl_wr;
  logic             w_stat_wr;
  logic [31:0]      w_rdata;

  // A new access is accepted only while ack is low, so each cyc&stb gets one ack.
  assign w_access  = wb_cyc_i & wb_stb_i & ~ack_q;
  assign w_wr      = w_access & wb_we_i;
  assign w_ctrl_wr = w_wr & (wb_adr_i == C_ADR_CTRL) & wb_sel_i[0];
  assign w_stat_wr = w_wr & (wb_adr_i == C_ADR_STATUS) & wb_sel_i[0];

  assign start_req_o = w_ctrl_wr & wb_dat_i[C_CTRL_START];
  assign abort_req_o = w_ctrl_wr & wb_dat_i[C_CTRL_ABORT];

  always_comb begin
    sel_d     = sel_q;
    div_d     = div_q;
    count_d   = count_q;
    done_d    = done_q;
    aborted_d = aborted_q;

    // Configuration is frozen for the duration of a burst.
    if (w_wr && !busy_i) begin
      case (wb_adr_i)
        C_ADR_CTRL:  if (wb_sel_i[0]) sel_d = wb_dat_i[C_CTRL_SEL];
        C_ADR_DIV:   div_d   = DIV_W'(byte_merge(32'(div_q), wb_dat_i, wb_sel_i));
        C_ADR_COUNT: count_d = CNT_W'(byte_merge(32'(count_q), wb_dat_i, wb_sel_i));
        default: ;
      endcase
    end

    // Hardware set beats the start-clear and the firmware W1C.
    if (done_set_i)
      done_d = 1'b1;
    else if (start_clr_i || (w_stat_wr && wb_dat_i[C_STAT_DONE]))
      done_d = 1'b0;

    if (aborted_set_i)
      aborted_d = 1'b1;
    else if (start_clr_i || (w_stat_wr && wb_dat_i[C_STAT_ABORTED]))
      aborted_d = 1'b0;
  end

  always_comb begin
    w_rdata = '0;
    case (wb_adr_i)
      C_ADR_CTRL:   w_rdata[C_CTRL_SEL] = sel_q;
      C_ADR_DIV:    w_rdata = 32'(div_q);
      C_ADR_COUNT:  w_rdata = 32'(count_q);
      C_ADR_STATUS: begin
        w_rdata[C_STAT_BUSY]    = busy_i;
        w_rdata[C_STAT_DONE]    = done_q;
        w_rdata[C_STAT_ABORTED] = aborted_q;
        w_rdata[C_STAT_EDGES_LSB +: C_EDGE_W] = edges_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q     <= 1'b0;
      dat_q     <= '0;
      sel_q     <= 1'b0;
      div_q     <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      ack_q     <= w_access;
      dat_q     <= (w_access && !wb_we_i) ? w_rdata : '0;
      sel_q     <= sel_d;
      div_q     <= div_d;
      count_q   <= count_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign wb_ack_o   = ack_q;
  assign wb_dat_o   = dat_q;
  assign sel_next_o = sel_d;
  assign div_o      = div_q;
  assign count_o    = count_q;
  assign done_o     = done_q;
  assign aborted_o  = aborted_q;

endmodule
`default_nettype wire

// File: rtl/clk_mon_pulse_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : clk_mon_pulse_gen                                                |
// | Purpose  : Programmable pulse-burst transmitter for the housekeeping        |
// |            clock-monitor pins. Emits COUNT rising edges with half-period    |
// |            DIV+1 cycles on the selected pin; the other pin stays low.       |
// | Ports    : wb_*        Wishbone slave (wb_clk_i sole clock, wb_rst_i sync   |
// |                        active-high reset)                                   |
// |            mon_core_o  core-clock monitor pin (mprj_io[14])                 |
// |            mon_user_o  user-clock monitor pin (mprj_io[15])                 |
// |            irq_o       level, high while STATUS.done is set                 |
// | Config   : CLK_MON_FREE_RUN_EN - when defined, a start with COUNT=0 runs    |
// |            continuously until abort; otherwise it completes immediately.    |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module clk_mon_pulse_gen
  import clk_mon_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int CNT_W = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [1:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        mon_core_o,
  output logic        mon_user_o,
  output logic        irq_o
);

  state_e              state_q;
  logic [DIV_W-1:0]    hp_q;
  logic [DIV_W-1:0]    div_lat_q;
  logic [CNT_W-1:0]    count_lat_q;
  logic                sel_lat_q;
  logic [C_EDGE_W-1:0] edges_q;
  logic                mon_core_q;
  logic                mon_user_q;
`ifdef CLK_MON_FREE_RUN_EN
  logic                free_q;
`endif

  logic             w_start_req;
  logic             w_abort_req;
  logic             w_sel_next;
  logic [DIV_W-1:0] w_div;
  logic [CNT_W-1:0] w_count;
  logic             w_done;
  logic             w_aborted;
  logic             w_busy;
  logic             w_hp_expired;
  logic             w_start_go;
  logic             w_count_zero;
  logic             w_last;
  logic             w_done_set;

  assign w_busy       = (state_q != ST_IDLE);
  assign w_hp_expired = (hp_q == '0);
  assign w_count_zero = (w_count == '0);
  // Abort in the same write as start cancels the start.
  assign w_start_go   = w_start_req & ~w_abort_req & ~w_busy;

  // End of the final high phase of a finite burst.
`ifdef CLK_MON_FREE_RUN_EN
  assign w_last = (state_q == ST_HIGH) & w_hp_expired & ~free_q &
                  (edges_q == C_EDGE_W'(count_lat_q));
  assign w_done_set = w_last & ~w_abort_req;
`else
  assign w_last = (state_q == ST_HIGH) & w_hp_expired &
                  (edges_q == C_EDGE_W'(count_lat_q));
  // A zero-length burst completes on the start access itself.
  assign w_done_set = (w_last & ~w_abort_req) | (w_start_go & w_count_zero);
`endif

  clk_mon_regs #(
    .DIV_W (DIV_W),
    .CNT_W (CNT_W)
  ) u_regs (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_i      (wb_rst_i),
    .wb_cyc_i      (wb_cyc_i),
    .wb_stb_i      (wb_stb_i),
    .wb_we_i       (wb_we_i),
    .wb_sel_i      (wb_sel_i),
    .wb_adr_i      (wb_adr_i),
    .wb_dat_i      (wb_dat_i),
    .wb_dat_o      (wb_dat_o),
    .wb_ack_o      (wb_ack_o),
    .busy_i        (w_busy),
    .done_set_i    (w_done_set),
    .aborted_set_i (w_abort_req & w_busy),
    .start_clr_i   (w_start_go),
    .edges_i       (edges_q),
    .start_req_o   (w_start_req),
    .abort_req_o   (w_abort_req),
    .sel_next_o    (w_sel_next),
    .div_o         (w_div),
    .count_o       (w_count),
    .done_o        (w_done),
    .aborted_o     (w_aborted)
  );

  // FSM, half-period counter, edge counter and registered pin outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      hp_q        <= '0;
      div_lat_q   <= '0;
      count_lat_q <= '0;
      sel_lat_q   <= 1'b0;
      edges_q     <= '0;
      mon_core_q  <= 1'b0;
      mon_user_q  <= 1'b0;
`ifdef CLK_MON_FREE_RUN_EN
      free_q      <= 1'b0;
`endif
    end else if (w_abort_req && w_busy) begin
      state_q    <= ST_IDLE;
      mon_core_q <= 1'b0;
      mon_user_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_start_go) begin
            edges_q <= '0;
`ifdef CLK_MON_FREE_RUN_EN
            free_q      <= w_count_zero;
            state_q     <= ST_LOW;
            hp_q        <= w_div;
            div_lat_q   <= w_div;
            count_lat_q <= w_count;
            sel_lat_q   <= w_sel_next;
`else
            if (!w_count_zero) begin
              state_q     <= ST_LOW;
              hp_q        <= w_div;
              div_lat_q   <= w_div;
              count_lat_q <= w_count;
              sel_lat_q   <= w_sel_next;
            end
`endif
          end
        end
        ST_LOW: begin
          if (w_hp_expired) begin
            state_q    <= ST_HIGH;
            hp_q       <= div_lat_q;
            mon_core_q <= ~sel_lat_q;
            mon_user_q <= sel_lat_q;
            edges_q    <= edges_q + 1'b1;
          end else begin
            hp_q <= hp_q - 1'b1;
          end
        end
        ST_HIGH: begin
          if (w_hp_expired) begin
            state_q    <= w_last ? ST_IDLE : ST_LOW;
            hp_q       <= div_lat_q;
            mon_core_q <= 1'b0;
            mon_user_q <= 1'b0;
          end else begin
            hp_q <= hp_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mon_core_o = mon_core_q;
  assign mon_user_o = mon_user_q;
  assign irq_o      = w_done;

  // The aborted flag is visible only through STATUS.
  logic w_unused;
  assign w_unused = w_aborted;

endmodule
`default_nettype wire
